// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a
// valid/ready output register that reports framing errors and overruns as pulses.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic [1:0] state_dbg
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int H  = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // Handshake: a byte transfers on any cycle where rx_valid and rx_ready are
   // both 1; rx_data is held stable for as long as rx_valid is 1.

   logic          sync1_q, rxs_q, rxs_d_q;
   logic [1:0]    fill_q;
   logic          armed_q;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          fe_q, fe_d;
   logic          ov_q, ov_d;

   // armed_q blocks start detection until the synchronizer has seen the real
   // line high after reset, so a line held low through reset cannot start a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
         rxs_d_q <= 1'b1;
         fill_q  <= 2'd0;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= rx_in;
         rxs_q   <= sync1_q;
         rxs_d_q <= rxs_q;
         if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
         if (fill_q == 2'd2 && rxs_q) armed_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      fe_d    = 1'b0;
      ov_d    = 1'b0;

      if (valid_q && rx_ready) valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (armed_q && !rxs_q && rxs_d_q) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rxs_q ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rxs_q;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rxs_q) begin
                  // A consumer taking the old byte this cycle frees room for the new one.
                  if (!valid_q || rx_ready) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     ov_d = 1'b1;
                  end
               end else begin
                  fe_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = fe_q;
   assign overrun   = ov_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 8 clocks per bit: directed frames, glitches, overrun,
// reset cases, then random frames against a byte queue and error-count model.
module tb_uart_rx;

   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic [1:0] state_dbg;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         fe_cnt  = 0;
   int         ov_cnt  = 0;
   bit         sb_on   = 1'b0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .state_dbg (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pulse counters and scoreboard: every consumed byte must be the oldest expected one.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         if (sb_on && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) check("sb_extra_byte", 32'(rx_valid), 32'd0);
            else check("sb_byte", 32'(rx_data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [9:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         rx_in = bits[i];
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_bits({stop, b, 1'b0}, 10);
   endtask

   task automatic consume();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   initial begin
      int         fe0, ov0, nonidle, gap, exp_fe;
      logic [7:0] b;
      logic       stop;

      rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data", 32'(rx_data), 32'h00);
      check("rst_valid", 32'(rx_valid), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      rst = 1'b0;
      idle(5);

      // Single frame with exact delivery latency
      fe0 = fe_cnt; ov0 = ov_cnt;
      fork
         send_frame(8'h55, 1'b1);
         begin
            repeat (78) @(posedge clk);
            @(negedge clk);
            check("single_early", 32'(rx_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("single_valid", 32'(rx_valid), 32'd1);
            check("single_data", 32'(rx_data), 32'h55);
         end
      join
      idle(4);
      check("single_no_ferr", 32'(fe_cnt), 32'(fe0));
      check("single_no_ovr", 32'(ov_cnt), 32'(ov0));
      consume();
      check("single_clear", 32'(rx_valid), 32'd0);

      // Back-to-back frames with rx_ready held high
      rx_ready = 1'b1;
      sb_on = 1'b1;
      exp_q.push_back(8'hA3);
      exp_q.push_back(8'h0F);
      send_frame(8'hA3, 1'b1);
      send_frame(8'h0F, 1'b1);
      idle(12);
      sb_on = 1'b0;
      rx_ready = 1'b0;
      check("b2b_drained", 32'(exp_q.size()), 32'd0);
      check("b2b_no_ovr", 32'(ov_cnt), 32'(ov0));

      // Short low glitch
      rx_in = 1'b0;
      repeat (2) @(negedge clk);
      rx_in = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch_valid", 32'(rx_valid), 32'd0);
      check("glitch_state", 32'(state_dbg), 32'd0);
      check("glitch_no_ferr", 32'(fe_cnt), 32'(fe0));

      // Framing error
      send_frame(8'hC4, 1'b0);
      idle(8);
      check("ferr_count", 32'(fe_cnt), 32'(fe0 + 1));
      check("ferr_valid", 32'(rx_valid), 32'd0);
      check("ferr_data", 32'(rx_data), 32'h0F);
      fe0 = fe_cnt;

      // Overrun: second byte dropped
      send_frame(8'h11, 1'b1);
      idle(3);
      send_frame(8'h22, 1'b1);
      idle(6);
      check("ovr_count", 32'(ov_cnt), 32'(ov0 + 1));
      check("ovr_data", 32'(rx_data), 32'h11);
      check("ovr_valid", 32'(rx_valid), 32'd1);
      ov0 = ov_cnt;
      consume();

      // Consumer reads in the delivery cycle: new byte replaces old, no overrun
      send_frame(8'h11, 1'b1);
      idle(3);
      check("ovr2_first", 32'(rx_data), 32'h11);
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (78) @(posedge clk);
            @(negedge clk);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            check("ovr2_data", 32'(rx_data), 32'h22);
            check("ovr2_valid", 32'(rx_valid), 32'd1);
         end
      join
      idle(4);
      check("ovr2_no_ovr", 32'(ov_cnt), 32'(ov0));

      // Reset during data bit 3, with a byte still pending
      send_bits({1'b1, 8'h5A, 1'b0}, 4);
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("arst_data", 32'(rx_data), 32'h00);
      check("arst_valid", 32'(rx_valid), 32'd0);
      check("arst_state", 32'(state_dbg), 32'd0);
      check("arst_pulses", 32'({frame_err, overrun}), 32'd0);
      @(negedge clk);
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(5);
      send_frame(8'h7E, 1'b1);
      idle(4);
      check("arst_next_data", 32'(rx_data), 32'h7E);
      check("arst_next_valid", 32'(rx_valid), 32'd1);
      check("arst_no_ferr", 32'(fe_cnt), 32'(fe0));
      consume();

      // Release reset with the line low: nothing may start until it rises and falls
      rst = 1'b1;
      rx_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      nonidle = 0;
      repeat (100) begin
         @(negedge clk);
         if (state_dbg != 2'd0) nonidle++;
      end
      check("low_rel_idle", 32'(nonidle), 32'd0);
      check("low_rel_valid", 32'(rx_valid), 32'd0);
      check("low_rel_no_ferr", 32'(fe_cnt), 32'(fe0));
      idle(8);
      send_frame(8'h3C, 1'b1);
      idle(4);
      check("low_rel_data", 32'(rx_data), 32'h3C);
      check("low_rel_got", 32'(rx_valid), 32'd1);
      consume();

      // Random frames: good ones queue their byte, bad stop bits count as framing errors
      rx_ready = 1'b1;
      sb_on = 1'b1;
      exp_fe = fe_cnt;
      for (int k = 0; k < 24; k++) begin
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         gap  = $urandom_range(0, 4);
         if (!stop && gap == 0) gap = 1;
         if (stop) exp_q.push_back(b);
         else exp_fe++;
         send_frame(b, stop);
         idle(gap);
      end
      idle(20);
      sb_on = 1'b0;
      rx_ready = 1'b0;
      check("rand_drained", 32'(exp_q.size()), 32'd0);
      check("rand_ferr", 32'(fe_cnt), 32'(exp_fe));
      check("rand_no_ovr", 32'(ov_cnt), 32'(ov0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive end of the UART: recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from the asynchronous `rx_in` line. Received bytes are held in an output data register with a valid/ready handshake toward the RX FIFO or core. The transmit datapath drives the same line format from the other end of the link. The block reports framing errors and overruns as single-cycle pulses.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868, gives clock cycles per bit (868 for 100 MHz at 115200 baud). Legal values are integers ≥ 4. Let H = floor(CLKS_PER_BIT/2).

Ports:
- `clk`  in  1  system clock; everything runs on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `rx_in`  in  1  serial line, asynchronous to `clk`; idles high.
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid` is also 1.
- `rx_data`  out  8  received byte. It is stable while `rx_valid`=1.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `overrun`  out  1  one-cycle pulse: a byte was lost because the register was still full.

## Operation
Synchronizer:
- Two-flop synchronizer on `rx_in`. Both flops reset to 1. Call its output `rxs`.
- A `rxs_d` flop also resets to 1.

FSM states: IDLE, START, DATA, STOP. Reset state is IDLE.
- IDLE: start is detected when `rxs`=0 and `rxs_d`=1, a true falling edge. A line held low never retriggers. On detection, clear the bit counter, clear the bit index, and go to START.
- START: count H cycles, then sample `rxs`.
  - Sample 0: clear the counter and go to DATA.
  - Sample 1: treat as a glitch and return to IDLE with no output activity.
- DATA: every CLKS_PER_BIT cycles, sample `rxs` into shift-register bit[index], LSB first. After index 7 is sampled, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample `rxs`, then return to IDLE.
  - Sample 1: the frame is good; apply the delivery rules below.
  - Sample 0: pulse `frame_err` and discard the byte. `rx_data` and `rx_valid` are unchanged.

Delivery rules, evaluated in the cycle of a good stop sample:
- `rx_valid`=0: load `rx_data` and set `rx_valid`.
- `rx_valid`=1 and `rx_ready`=1: load the new byte. `rx_valid` stays 1 and there is no overrun.
- `rx_valid`=1 and `rx_ready`=0: keep the old byte, drop the new one, and pulse `overrun`.

Handshake and counters:
- `rx_valid` clears on any cycle with `rx_valid`=1 and `rx_ready`=1, unless a new byte loads in that same cycle.
- The bit counter is ceil(log2(CLKS_PER_BIT)) bits wide and counts from 0 to CLKS_PER_BIT-1. It has no wrap-around beyond its terminal count.
- The bit index is 3 bits and counts 0 to 7.

Reset values:
- `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0.
- Shift register = 0, counters = 0.
- Reset mid-frame aborts the frame with no pulses.
  - After reset is released, the next falling edge starts a new frame.
  - If the line is still low at release, the block waits for it to go high and then low again.

## Timing
Let cycle D be the first cycle in which IDLE sees `rxs`=0 with `rxs_d`=1. D falls 2–3 cycles after `rx_in` falls.
- Start sample: D+H.
- Data bit i (0..7) sample: D+H+(i+1)·CLKS_PER_BIT.
- Stop sample: D+H+9·CLKS_PER_BIT.
- `rx_valid` (for a good frame), `frame_err` and `overrun` are registered and assert in the cycle after the stop sample.
- The FSM is in IDLE in the cycle after the stop sample. This means a start bit that begins immediately after the stop bit's mid-point is caught, so back-to-back frames work.
- Sampling at bit centre tolerates ±(H−3)/CLKS_PER_BIT of a bit of skew accumulated over the frame.

## Test plan
Use CLKS_PER_BIT=8 and hold `rx_ready`=0 unless stated.
- Single frame: drive 0x55 as 8N1 → `rx_data`=0x55 and `rx_valid`=1 at D+4+72+1; no pulses. Then drive `rx_ready`=1 for one cycle → `rx_valid`=0 on the next cycle.
- Back-to-back frames: drive 0xA3 then 0x0F with no idle gap, and `rx_ready`=1 throughout → two one-cycle `rx_valid` pulses with `rx_data` 0xA3 then 0x0F; no `overrun`.
- Glitch and framing:
  - Pulse `rx_in` low for 2 cycles → no `rx_valid` and no `frame_err`; the FSM is back in IDLE.
  - Drive 0xC4 with stop bit 0 → one `frame_err` pulse; `rx_valid` stays 0; `rx_data` is unchanged.
- Overrun: receive 0x11 and do not read it, then receive 0x22 → one `overrun` pulse; `rx_data` stays 0x11.
  - Repeat with `rx_ready`=1 held only in the delivery cycle of 0x22 → `rx_data`=0x22, `rx_valid`=1, no `overrun`.
- Reset mid-frame:
  - Assert `rst` during data bit 3 of 0x5A → all outputs go to 0 asynchronously.
  - Release `rst` while the line is still high, then drive 0x7E → `rx_data`=0x7E with no `frame_err`.
  - Release `rst` while the line is held low → no frame starts until the line goes high and then falls again.
